ttc_intr_arbiter12: RTL and testbench
=====================================

TTC_INTR_ARBITER12 -- requirements
Module: ttc_intr_arbiter12

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, meaning cycles irq12 stays asserted without acknowledge before abandonment (legal range 2..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, meaning post-clear wait cycles before re-arbitration (legal range 1..7).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 pclk12  input  1  system clock; all state updates on rising edge.
REQ-005 p_reset12  input  1  synchronous active-high reset.
REQ-006 intr_in12  input  3  interrupt level from timer channel 0..2.
REQ-007 intr_mask12  input  3  1 = channel excluded from arbitration.
REQ-008 intr_ack12  input  1  CPU acknowledge, one-cycle pulse.
REQ-009 timeout_clr12  input  1  clears the sticky timeout flag.
REQ-010 irq12  output  1  interrupt request to CPU.
REQ-011 irq_id12  output  2  granted channel index, valid while irq12=1.
REQ-012 clear_interrupt12  output  3  one-hot, one-cycle clear pulse to the granted channel.
REQ-013 timeout12  output  1  sticky flag, ack timeout occurred.
REQ-014 busy12  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ASSERT, CLEAR, HOLD; all outputs registered or decoded from registered state only.
REQ-016 Eligible set SHALL be intr_in12 & ~intr_mask12, sampled only in IDLE.
REQ-017 In IDLE with a non-empty eligible set, next edge SHALL enter ASSERT and latch the winner into irq_id12 (irq12 high one cycle after request seen).
REQ-018 irq12 SHALL be 1 exactly while state is ASSERT; irq_id12 SHALL hold its value outside ASSERT.
REQ-019 In ASSERT, intr_ack12=1 SHALL move to CLEAR at next edge.
REQ-020 In ASSERT, an 8-bit wait counter SHALL start at 0 on entry and increment each cycle; when it equals ACK_TIMEOUT-1 with no ack, next edge SHALL set timeout12, go to IDLE, emit no clear, and advance the RR pointer past irq_id12.
REQ-021 Ack and timeout on the same cycle: ack SHALL win; timeout12 not set.
REQ-022 In ASSERT, if intr_in12[irq_id12] drops before ack, next edge SHALL return to IDLE without clear and without pointer change (spurious request).
REQ-023 Mask changes during ASSERT/CLEAR/HOLD SHALL not affect the current grant.
REQ-024 CLEAR SHALL last one cycle with clear_interrupt12 = one-hot(irq_id12); clear_interrupt12 SHALL be 0 in all other states.
REQ-025 On leaving CLEAR, RR pointer SHALL become (irq_id12+1) mod 3; FSM enters HOLD.
REQ-026 HOLD SHALL last exactly HOLD_CYCLES cycles, ignoring all inputs except reset, then return to IDLE.
REQ-027 intr_ack12 outside ASSERT SHALL be ignored.
REQ-028 timeout_clr12=1 SHALL clear timeout12 next edge; simultaneous set and clear: set wins.
REQ-029 busy12 SHALL equal (state != IDLE).

Reset
REQ-030 p_reset12=1 SHALL, at next edge, force IDLE, RR pointer 0, counters 0, irq12=0, irq_id12=0, clear_interrupt12=0, timeout12=0, busy12=0.
REQ-031 Reset during ASSERT or CLEAR SHALL abort with no clear pulse emitted after the reset edge.

Configuration
REQ-032 Macro TTC_ARB_ROUND_ROBIN_EN defined: winner SHALL be the first eligible channel searching upward from the RR pointer, wrapping 2->0.
REQ-033 Macro undefined: fixed priority channel 0 > 1 > 2; RR pointer logic SHALL be absent and pointer-advance rules have no effect.

Verification
REQ-034 Reset, intr_in12=3'b010, mask 0 -> irq12=1, irq_id12=1 one cycle later; ack -> clear_interrupt12=3'b010 for one cycle; busy12 low after HOLD_CYCLES.
REQ-035 RR_EN defined, intr_in12=3'b111 held, ack each grant -> grant order 0,1,2,0; RR_EN undefined -> 0,0,0.
REQ-036 intr_in12=3'b001, no ack -> irq12 high exactly 64 cycles, then low, timeout12=1, no clear pulse; timeout_clr12 pulse -> timeout12=0.
REQ-037 Ack on the 64th ASSERT cycle -> CLEAR taken, timeout12 stays 0.
REQ-038 intr_mask12=3'b001, intr_in12=3'b101 -> irq_id12=2; channel 0 never granted while masked.
REQ-039 p_reset12 asserted during ASSERT -> irq12=0 next edge, clear_interrupt12 stays 0, state IDLE.

Source files
------------

// File: rtl/ttc_intr_arbiter12.sv
// Three-channel timer interrupt arbiter with ack timeout and post-clear hold.
// Define TTC_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module ttc_intr_arbiter12 #(
  parameter int ACK_TIMEOUT = 64,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       pclk12,
  input  logic       p_reset12,
  input  logic [2:0] intr_in12,
  input  logic [2:0] intr_mask12,
  input  logic       intr_ack12,
  input  logic       timeout_clr12,
  output logic       irq12,
  output logic [1:0] irq_id12,
  output logic [2:0] clear_interrupt12,
  output logic       timeout12,
  output logic       busy12
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_CLEAR, S_HOLD} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_id, w_id_nxt;
  logic [7:0] r_wait, w_wait_nxt;
  logic [2:0] r_hold, w_hold_nxt;
  logic       r_timeout, w_timeout_nxt, w_to_set;
  logic [2:0] w_elig;
  logic [1:0] w_win;

  assign w_elig = intr_in12 & ~intr_mask12;

`ifdef TTC_ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr, w_ptr_nxt, w_id_plus1;

  assign w_id_plus1 = (r_id == 2'd2) ? 2'd0 : r_id + 2'd1;

  // Search upward from the pointer, wrapping 2 -> 0.
  always_comb begin
    w_win = 2'd0;
    case (r_ptr)
      2'd1:    w_win = w_elig[1] ? 2'd1 : (w_elig[2] ? 2'd2 : 2'd0);
      2'd2:    w_win = w_elig[2] ? 2'd2 : (w_elig[0] ? 2'd0 : 2'd1);
      default: w_win = w_elig[0] ? 2'd0 : (w_elig[1] ? 2'd1 : 2'd2);
    endcase
  end
`else
  always_comb begin
    w_win = w_elig[0] ? 2'd0 : (w_elig[1] ? 2'd1 : 2'd2);
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_wait_nxt  = r_wait;
    w_hold_nxt  = r_hold;
    w_to_set    = 1'b0;
`ifdef TTC_ARB_ROUND_ROBIN_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_elig != 3'b000) begin
          w_state_nxt = S_ASSERT;
          w_id_nxt    = w_win;
          w_wait_nxt  = 8'd0;
        end
      end
      S_ASSERT: begin
        // Ack beats both a dropped request and the timeout on the same cycle.
        if (intr_ack12) begin
          w_state_nxt = S_CLEAR;
        end else if (!intr_in12[r_id]) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_IDLE;
          w_to_set    = 1'b1;
`ifdef TTC_ARB_ROUND_ROBIN_EN
          w_ptr_nxt   = w_id_plus1;
`endif
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_HOLD;
        w_hold_nxt  = 3'd0;
`ifdef TTC_ARB_ROUND_ROBIN_EN
        w_ptr_nxt   = w_id_plus1;
`endif
      end
      default: begin
        if (r_hold == HOLD_LAST) w_state_nxt = S_IDLE;
        else w_hold_nxt = r_hold + 3'd1;
      end
    endcase
    w_timeout_nxt = w_to_set | (r_timeout & ~timeout_clr12);
  end

  always_ff @(posedge pclk12) begin
    if (p_reset12) begin
      r_state   <= S_IDLE;
      r_id      <= 2'd0;
      r_wait    <= 8'd0;
      r_hold    <= 3'd0;
      r_timeout <= 1'b0;
`ifdef TTC_ARB_ROUND_ROBIN_EN
      r_ptr     <= 2'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_id      <= w_id_nxt;
      r_wait    <= w_wait_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
`ifdef TTC_ARB_ROUND_ROBIN_EN
      r_ptr     <= w_ptr_nxt;
`endif
    end
  end

  assign irq12             = (r_state == S_ASSERT);
  assign irq_id12          = r_id;
  assign clear_interrupt12 = (r_state == S_CLEAR) ? (3'b001 << r_id) : 3'b000;
  assign timeout12         = r_timeout;
  assign busy12            = (r_state != S_IDLE);

endmodule

// File: tb/tb_ttc_intr_arbiter12.sv
// Bench for ttc_intr_arbiter12: directed scenarios plus randomized traffic
// checked every cycle against a behavioural grant/clear model.
module tb_ttc_intr_arbiter12;
  localparam int TO = 64;
  localparam int HC = 2;

  logic       clk = 1'b0;
  logic       rst, ack, tclr;
  logic [2:0] in_v, mask;
  logic       irq, to_flag, busy;
  logic [1:0] irq_id;
  logic [2:0] clr;

  always #5 clk = ~clk;

  ttc_intr_arbiter12 #(.ACK_TIMEOUT(TO), .HOLD_CYCLES(HC)) dut (
    .pclk12(clk), .p_reset12(rst), .intr_in12(in_v), .intr_mask12(mask),
    .intr_ack12(ack), .timeout_clr12(tclr), .irq12(irq), .irq_id12(irq_id),
    .clear_interrupt12(clr), .timeout12(to_flag), .busy12(busy)
  );

  int passed = 0;
  int total  = 0;
  int clr_count = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: phase 0 idle, 1 requesting, 2 clearing, 3 holding.
  int         m_phase = 0;
  int         m_age = 0;
  int         m_ptr = 0;
  int         m_id = 0;
  bit         m_to = 1'b0;
  logic [1:0] exp_q[$];

  function automatic int pick(input logic [2:0] e, input int ptr);
    for (int k = 0; k < 3; k++) begin
`ifdef TTC_ARB_ROUND_ROBIN_EN
      int idx = (ptr + k) % 3;
`else
      int idx = k;
`endif
      if (e[idx]) return idx;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    bit set_to;
    set_to = 1'b0;
    if (rst) begin
      m_phase = 0; m_age = 0; m_ptr = 0; m_id = 0; m_to = 1'b0;
      exp_q.delete();
    end else begin
      if (m_phase == 0) begin
        if ((in_v & ~mask) != 3'b000) begin
          m_id = pick(in_v & ~mask, m_ptr);
          m_phase = 1; m_age = 1;
        end
      end else if (m_phase == 1) begin
        if (ack) begin
          m_phase = 2; exp_q.push_back(2'(m_id));
        end else if (!in_v[m_id]) begin
          m_phase = 0;
        end else if (m_age == TO) begin
          m_phase = 0; set_to = 1'b1; m_ptr = (m_id + 1) % 3;
        end else begin
          m_age++;
        end
      end else if (m_phase == 2) begin
        m_phase = 3; m_age = 1; m_ptr = (m_id + 1) % 3;
      end else begin
        if (m_age == HC) m_phase = 0;
        else m_age++;
      end
      if (set_to) m_to = 1'b1;
      else if (tclr) m_to = 1'b0;
    end
  end

  logic [2:0] e_clr;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      e_clr = 3'b000;
      if (m_phase == 2 && exp_q.size() > 0) e_clr = 3'b001 << exp_q.pop_front();
      if (clr != 3'b000) clr_count++;
      total++;
      if (irq === (m_phase == 1) && irq_id === 2'(m_id) && clr === e_clr &&
          to_flag === m_to && busy === (m_phase != 0))
        passed++;
      else
        $display("FAIL cycle_check t=%0t got/expected: irq %b/%b id %0d/%0d clr %b/%b to %b/%b busy %b/%b",
                 $time, irq, (m_phase == 1), irq_id, m_id, clr, e_clr, to_flag, m_to, busy, (m_phase != 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_v = 3'b000; mask = 3'b000; ack = 1'b0; tclr = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_irq(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (irq) begin ok = 1'b1; return; end
      cyc();
    end
  endtask

  initial begin
    bit ok;
    int n, c0;
    int ord[4];
`ifdef TTC_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{0, 0, 0, 0};
`endif

    // Reset state
    do_reset();
    chk_en = 1'b1;
    chk("rst_irq", irq, 0); chk("rst_id", irq_id, 0); chk("rst_clr", clr, 0);
    chk("rst_to", to_flag, 0); chk("rst_busy", busy, 0);

    // Single request on channel 1, ack, then hold
    in_v = 3'b010;
    cyc();
    chk("ch1_irq", irq, 1); chk("ch1_id", irq_id, 1);
    ack = 1'b1;
    cyc();
    ack = 1'b0; in_v = 3'b000;
    chk("ch1_clr", clr, 3'b010);
    cyc();
    chk("ch1_clr_gone", clr, 0); chk("ch1_hold_busy", busy, 1);
    cyc();
    chk("ch1_hold_busy2", busy, 1);
    cyc();
    chk("ch1_idle", busy, 0);

    // Grant order with all channels held
    do_reset();
    in_v = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_irq(10, ok);
      chk("order_wait", ok, 1);
      chk("grant_order", irq_id, ord[g]);
      ack = 1'b1; cyc(); ack = 1'b0; cyc();
    end
    in_v = 3'b000;

    // Ack timeout
    do_reset();
    c0 = clr_count;
    in_v = 3'b001;
    wait_irq(5, ok);
    chk("to_wait", ok, 1);
    n = 0;
    while (irq && n < 200) begin n++; cyc(); end
    in_v = 3'b000;
    chk("to_irq_cycles", n, TO);
    chk("to_flag_set", to_flag, 1);
    chk("to_no_clear", clr_count - c0, 0);
    cyc();
    chk("to_sticky", to_flag, 1);
    tclr = 1'b1; cyc(); tclr = 1'b0;
    chk("to_cleared", to_flag, 0);

    // Ack on the last possible ASSERT cycle
    do_reset();
    in_v = 3'b001;
    wait_irq(5, ok);
    for (int i = 1; i < TO; i++) cyc();
    chk("late_irq", irq, 1);
    ack = 1'b1; cyc(); ack = 1'b0; in_v = 3'b000;
    chk("late_clr", clr, 3'b001); chk("late_to", to_flag, 0);
    cyc(); cyc(); cyc();

    // Masked channel 0 never granted
    do_reset();
    mask = 3'b001; in_v = 3'b101;
    for (int g = 0; g < 3; g++) begin
      wait_irq(10, ok);
      chk("mask_wait", ok, 1);
      chk("mask_id", irq_id, 2);
      ack = 1'b1; cyc(); ack = 1'b0; cyc();
    end
    mask = 3'b000; in_v = 3'b000;

    // Reset during ASSERT
    do_reset();
    in_v = 3'b010;
    wait_irq(5, ok);
    c0 = clr_count;
    rst = 1'b1; ack = 1'b1;
    cyc();
    rst = 1'b0; ack = 1'b0; in_v = 3'b000;
    chk("rstA_irq", irq, 0); chk("rstA_busy", busy, 0); chk("rstA_id", irq_id, 0);
    cyc(); cyc();
    chk("rstA_no_clear", clr_count - c0, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) in_v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) mask = 3'($urandom_range(0, 7));
      ack  = ($urandom_range(0, 5) == 0);
      tclr = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; ack = 1'b0; tclr = 1'b0;
    cyc();
    chk_en = 1'b0;
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
